io_input_cond: RTL and testbench
================================

IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 Parameter TICK_DIV, default 50000, sets the sample-tick period in i_clk cycles (1 ms at 50 MHz); legal range 2 to 2^20.
REQ-002 Parameter DB_TICKS, default 8, sets the number of consecutive disagreeing ticks needed to change a debounced level; legal range 1 to 15.
REQ-003 i_clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_raw_sw  input  32  raw board slide switches, asynchronous, active-high.
REQ-006 i_raw_btn_n  input  4  raw board push-buttons, asynchronous, active-low.
REQ-007 i_clr  input  4  per-button sticky clear, synchronous, one bit per button.
REQ-008 o_io_sw  output  32  debounced switches; this output feeds the CPU i_io_sw port.
REQ-009 o_io_btn  output  4  debounced buttons, active-high (1 = pressed); this output feeds the CPU i_io_btn port.
REQ-010 o_btn_press  output  4  one-cycle pulse on each debounced press edge (0 to 1).
REQ-011 o_btn_sticky  output  4  press latch, held until cleared.
REQ-012 o_tick  output  1  one-cycle sample-tick strobe.

Function
REQ-013 Buttons SHALL be inverted before synchronisation, so every channel is active-high internally.
REQ-014 Each of the 36 channels SHALL pass through a 2-flop synchroniser before any other logic.
REQ-015 The prescaler SHALL count 0 to TICK_DIV-1 and then wrap to 0.
REQ-016 o_tick SHALL be 1 for exactly the cycle in which the prescaler equals TICK_DIV-1, giving a period of TICK_DIV cycles.
REQ-017 Each channel SHALL run a 4-state FSM: S_LO, S_PEND_HI, S_HI, S_PEND_LO.
REQ-018 The channel FSM and its counter SHALL change only in cycles where o_tick=1.
REQ-019 S_LO: a synchronised sample of 1 SHALL move the channel to S_PEND_HI with cnt=1, or directly to S_HI if DB_TICKS=1.
REQ-020 S_PEND_HI: a sample of 1 SHALL increment cnt; on reaching DB_TICKS the channel SHALL move to S_HI with cnt=0.
REQ-021 S_PEND_HI: a sample of 0 SHALL return the channel to S_LO with cnt=0 (glitch rejected, output unchanged).
REQ-022 S_HI and S_PEND_LO SHALL behave symmetrically to REQ-019..REQ-021 with the levels swapped.
REQ-023 The debounced level SHALL be 1 in S_HI and S_PEND_LO, and 0 otherwise; it is registered.
REQ-024 The debounced level SHALL change in the cycle after the DB_TICKS-th consecutive disagreeing tick.
REQ-025 Worst-case latency from a raw edge to a debounced change SHALL be 2 + DB_TICKS*TICK_DIV + 1 cycles.
REQ-026 o_btn_press[i] SHALL be 1 for exactly the one cycle in which o_io_btn[i] first reads 1 after reading 0.
REQ-027 A release SHALL produce no pulse on o_btn_press.
REQ-028 o_btn_sticky[i] SHALL set on o_btn_press[i] and clear on i_clr[i].
REQ-029 When o_btn_press[i] and i_clr[i] occur in the same cycle, set SHALL win.
REQ-030 A raw input toggling every tick SHALL never change the debounced output.
REQ-031 The cnt register SHALL saturate at DB_TICKS and never wrap.

Reset
REQ-032 With rst=0 at a clock edge, every output SHALL be 0 in the following cycle: o_io_sw, o_io_btn, o_btn_press, o_btn_sticky, o_tick.
REQ-033 Reset SHALL also clear the synchronisers to 0, the prescaler to 0, every FSM to S_LO and every cnt to 0.
REQ-034 Reset asserted mid-debounce SHALL discard the pending state; after rst returns to 1, a held input SHALL again need the full DB_TICKS ticks.
REQ-035 No press pulse SHALL be generated by reset release, even when a button is held through reset.

Structure
REQ-036 Package io_cond_pkg SHALL hold the channel-state enum (S_LO, S_PEND_HI, S_HI, S_PEND_LO), the default values of TICK_DIV and DB_TICKS, and NUM_SW=32 and NUM_BTN=4.
REQ-037 Sub-module debounce_ch SHALL contain one channel (synchroniser, FSM, cnt, level) and be instantiated 36 times by generate.
REQ-038 The prescaler and the edge/sticky logic SHALL reside in io_input_cond.

Verification (TICK_DIV=4, DB_TICKS=3)
REQ-039 Reset: hold rst=0 for 3 cycles with i_raw_btn_n=4'b0000 -> all outputs are 0; after release, o_tick first pulses 4 cycles later; the press pulse and o_btn_io=0xF appear only after 3 ticks.
REQ-040 Clean press: drive i_raw_btn_n[0]=0 -> o_io_btn[0] rises within 2+12+1 cycles; o_btn_press[0] is high for 1 cycle; o_btn_sticky[0]=1.
REQ-041 Glitch: drive i_raw_sw[5]=1 for 2 ticks, then 0 -> o_io_sw[5] stays 0 and the FSM returns to S_LO.
REQ-042 Sticky race: assert i_clr[1]=1 in the same cycle as o_btn_press[1] -> o_btn_sticky[1]=1; assert i_clr[1] one cycle later -> o_btn_sticky[1]=0.
REQ-043 Release: after a debounced press, set i_raw_btn_n[2]=1 for 3 ticks -> o_io_btn[2] falls to 0 with no press pulse.
REQ-044 Mid-debounce reset: drive i_raw_sw=0xFFFFFFFF, assert rst after 2 ticks -> o_io_sw=0 after reset; after release, o_io_sw reads 0xFFFFFFFF only after 3 further ticks.

Source files
------------

// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared types and constants for board input conditioning
package io_cond_pkg;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_PEND_HI = 2'd1,
        S_HI      = 2'd2,
        S_PEND_LO = 2'd3
    } ch_state_t;

    localparam int TICK_DIV_DEF = 50000;
    localparam int DB_TICKS_DEF = 8;
    localparam int NUM_SW       = 32;
    localparam int NUM_BTN      = 4;
    localparam int NUM_CH       = NUM_SW + NUM_BTN;
    localparam int CNT_W        = 4;
    localparam int PRE_W        = 20;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one input channel: 2-flop synchroniser and tick-driven debounce FSM
module debounce_ch
    import io_cond_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic i_clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] DB = CNT_W'(DB_TICKS);

    logic             r_sync1;
    logic             r_sync2;
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_level;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= S_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == S_HI) || (w_state_nxt == S_PEND_LO);
        end
    end

    // Saturating increment keeps cnt bounded by DB_TICKS
    assign w_cnt_inc = (r_cnt >= DB) ? DB : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_tick) begin
            case (r_state)
                S_LO: begin
                    if (r_sync2) begin
                        if (DB_TICKS == 1) begin
                            w_state_nxt = S_HI;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_PEND_HI;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_PEND_HI: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_LO;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == DB) begin
                        w_state_nxt = S_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                S_HI: begin
                    if (!r_sync2) begin
                        if (DB_TICKS == 1) begin
                            w_state_nxt = S_LO;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_PEND_LO;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_PEND_LO: begin
                    if (r_sync2) begin
                        w_state_nxt = S_HI;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == DB) begin
                        w_state_nxt = S_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - debounces board switches/buttons, generates press pulses and sticky latches
module io_input_cond
    import io_cond_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  i_raw_sw,
    input  logic [NUM_BTN-1:0] i_raw_btn_n,
    input  logic [NUM_BTN-1:0] i_clr,
    output logic [NUM_SW-1:0]  o_io_sw,
    output logic [NUM_BTN-1:0] o_io_btn,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_sticky,
    output logic               o_tick
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]   r_presc;
    logic               w_tick;
    logic [NUM_CH-1:0]  w_raw;
    logic [NUM_CH-1:0]  w_level;
    logic [NUM_BTN-1:0] r_btn_prev;
    logic [NUM_BTN-1:0] r_sticky;
    logic [NUM_BTN-1:0] w_press;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (r_presc == PRE_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    assign w_tick = (r_presc == PRE_MAX);

    // Buttons are inverted up front so every channel is active-high
    assign w_raw = {~i_raw_btn_n, i_raw_sw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .DB_TICKS (DB_TICKS)
        ) u_ch (
            .i_clk   (i_clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g])
        );
    end

    assign o_io_sw  = w_level[NUM_SW-1:0];
    assign o_io_btn = w_level[NUM_CH-1:NUM_SW];

    assign w_press = o_io_btn & ~r_btn_prev;

    // Set takes priority over clear when both land in the same cycle
    always_ff @(posedge i_clk) begin
        if (!rst) begin
            r_btn_prev <= '0;
            r_sticky   <= '0;
        end else begin
            r_btn_prev <= o_io_btn;
            r_sticky   <= (r_sticky & ~i_clr) | w_press;
        end
    end

    assign o_btn_press  = w_press;
    assign o_btn_sticky = r_sticky;
    assign o_tick       = w_tick;

endmodule

// File: tb/tb_io_input_cond.sv
// tb/tb_io_input_cond.sv - randomized scoreboard bench for io_input_cond
module tb_io_input_cond;

    localparam int TD = 4;
    localparam int DB = 3;

    logic        i_clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_raw_sw = '0;
    logic [3:0]  i_raw_btn_n = '0;
    logic [3:0]  i_clr = '0;
    logic [31:0] o_io_sw;
    logic [3:0]  o_io_btn;
    logic [3:0]  o_btn_press;
    logic [3:0]  o_btn_sticky;
    logic        o_tick;

    io_input_cond #(.TICK_DIV(TD), .DB_TICKS(DB)) dut (
        .i_clk        (i_clk),
        .rst          (rst),
        .i_raw_sw     (i_raw_sw),
        .i_raw_btn_n  (i_raw_btn_n),
        .i_clr        (i_clr),
        .o_io_sw      (o_io_sw),
        .o_io_btn     (o_io_btn),
        .o_btn_press  (o_btn_press),
        .o_btn_sticky (o_btn_sticky),
        .o_tick       (o_tick)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [3:0]  press;
        logic [3:0]  sticky;
        logic        tick;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference: each channel keeps its level and the length of the current run of
    // tick samples that disagree with it; the level flips when that run reaches DB.
    logic [35:0] m_s1, m_s2, m_level;
    int          m_run[36];
    int          m_cyc;
    logic [3:0]  m_prev, m_sticky;
    exp_t        last_exp;

    task automatic model_edge();
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_cyc = 0; m_prev = '0; m_sticky = '0;
            for (int c = 0; c < 36; c++) m_run[c] = 0;
        end else begin
            logic [3:0] press_now;
            press_now = m_level[35:32] & ~m_prev;
            m_sticky  = (m_sticky & ~i_clr) | press_now;
            m_prev    = m_level[35:32];
            if (m_cyc % TD == TD - 1) begin
                for (int c = 0; c < 36; c++) begin
                    if (m_s2[c] != m_level[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DB) begin
                            m_level[c] = ~m_level[c];
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            m_s2  = m_s1;
            m_s1  = {~i_raw_btn_n, i_raw_sw};
            m_cyc = m_cyc + 1;
        end
        last_exp.sw     = m_level[31:0];
        last_exp.btn    = m_level[35:32];
        last_exp.press  = m_level[35:32] & ~m_prev;
        last_exp.sticky = m_sticky;
        last_exp.tick   = (m_cyc % TD == TD - 1);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_edge();
        sb.push_back(last_exp);
        #1;
    endtask

    task automatic rand_clr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      i_clr = 4'($urandom);
        else if (r < 3)  i_clr = last_exp.press;
        else             i_clr = '0;
    endtask

    task automatic flip_random(input int odds);
        for (int b = 0; b < 32; b++)
            if ($urandom_range(0, odds - 1) == 0) i_raw_sw[b] = ~i_raw_sw[b];
        for (int b = 0; b < 4; b++)
            if ($urandom_range(0, odds - 1) == 0) i_raw_btn_n[b] = ~i_raw_btn_n[b];
    endtask

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk1("io_sw",      o_io_sw,               e.sw);
                chk1("io_btn",     {28'd0, o_io_btn},     {28'd0, e.btn});
                chk1("btn_press",  {28'd0, o_btn_press},  {28'd0, e.press});
                chk1("btn_sticky", {28'd0, o_btn_sticky}, {28'd0, e.sticky});
                chk1("tick",       {31'd0, o_tick},       {31'd0, e.tick});
            end
        end
    end

    initial begin : stim
        for (int c = 0; c < 36; c++) m_run[c] = 0;
        // Reset with all buttons held, then keep holding through release
        rst = 1'b0; i_raw_btn_n = 4'b0000;
        repeat (3) step();
        rst = 1'b1;
        repeat (30) begin step(); rand_clr(); end
        // Slow-moving random inputs: mostly clean presses/releases
        repeat (1500) begin step(); flip_random(40); rand_clr(); end
        // Fast-moving random inputs: mostly glitches
        repeat (400) begin step(); flip_random(5); rand_clr(); end
        // Toggle every tick: debounced switches must not move
        for (int k = 0; k < 80; k++) begin
            step();
            if (k % TD == 0) i_raw_sw = ~i_raw_sw;
            i_clr = '0;
        end
        // Reset in the middle of a debounce, then re-debounce from scratch
        i_raw_sw = '0; i_raw_btn_n = 4'hF;
        repeat (30) step();
        i_raw_sw = 32'hFFFF_FFFF;
        repeat (8) step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (25) step();
        repeat (600) begin step(); flip_random(30); rand_clr(); end
        @(negedge i_clk);
        #1;
        chk1("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
